// File: rtl/btn_cmd_arbiter.sv
// Push-button front end: 2-flop sync, tick-sampled debounce, press detection,
// per-button pending requests and a round-robin valid/ready command port.
module btn_cmd_arbiter #(
  parameter int N_BTN    = 4,
  parameter int ID_W     = 2,
  parameter int TICK_DIV = 250000,
  parameter int STABLE_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  input  logic             cmd_ready,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overrun
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_OFFER} state_e;

  logic [N_BTN-1:0]    sync1_q, sync2_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic [STABLE_N-1:0] hist_q [N_BTN];
  logic [STABLE_N-1:0] hist_d [N_BTN];
  logic [N_BTN-1:0]    deb_q, deb_d;
  logic [N_BTN-1:0]    press;
  logic [N_BTN-1:0]    pend_q, pend_d;
  logic [N_BTN-1:0]    ovr_q, ovr_d;
  logic [N_BTN-1:0]    issue;
  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic                found;
  logic [ID_W-1:0]     winner;

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    for (int i = 0; i < N_BTN; i++) begin
      hist_d[i] = hist_q[i];
      deb_d[i]  = deb_q[i];
      if (tick) begin
        hist_d[i] = {hist_q[i][STABLE_N-2:0], sync2_q[i]};
        if (&hist_d[i])       deb_d[i] = 1'b1;
        else if (~|hist_d[i]) deb_d[i] = 1'b0;
      end
    end
  end

  assign press = deb_d & ~deb_q;

  // Search begins just past the last winner and wraps; only registered pending bits compete.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      int j;
      j = (int'(last_q) + k) % N_BTN;
      if (!found && pend_q[j]) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    issue   = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_OFFER;
          id_d    = winner;
          last_d  = winner;
          issue   = N_BTN'(1) << winner;
        end
      end
      ST_OFFER: begin
        if (cmd_ready) begin
          if (found) begin
            id_d   = winner;
            last_d = winner;
            issue  = N_BTN'(1) << winner;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A press coinciding with its own issue re-arms the request as a fresh event.
  assign pend_d = (pend_q & ~issue) | press;
  assign ovr_d  = ovr_q | (press & pend_q & ~issue);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
      state_q <= ST_IDLE;
      id_q    <= '0;
      last_q  <= ID_W'(N_BTN - 1);
      // NOTE: the history array is only a few flops per button, so it is reset with everything else.
      for (int i = 0; i < N_BTN; i++) hist_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      for (int i = 0; i < N_BTN; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign cmd_valid = (state_q == ST_OFFER);
  assign cmd_id    = id_q;
  assign pending   = pend_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Self-checking bench for btn_cmd_arbiter: directed table, corner sequences and a
// randomized run compared against a run-length/round-robin behavioural model.
module tb_btn_cmd_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TD = 4;
  localparam int SN = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  btn_raw;
  logic          cmd_valid;
  logic [IW-1:0] cmd_id;
  logic          cmd_ready;
  logic [N-1:0]  pending;
  logic [N-1:0]  overrun;

  btn_cmd_arbiter #(.N_BTN(N), .ID_W(IW), .TICK_DIV(TD), .STABLE_N(SN)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .cmd_valid(cmd_valid),
    .cmd_id(cmd_id), .cmd_ready(cmd_ready), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_id[$];
  int acc_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: debounce as runs of equal tick samples, arbitration as a wrapped scan.
  int           m_cnt;
  logic [N-1:0] m_s1, m_s2, m_deb, m_pend, m_ovr;
  int           m_ones[N];
  int           m_zeros[N];
  logic         m_valid;
  int           m_id, m_last;

  task automatic model_reset();
    m_cnt = 0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_pend = '0; m_ovr = '0;
    m_valid = 1'b0; m_id = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      m_ones[i]  = 0;
      m_zeros[i] = SN;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] raw, input logic rdy);
    logic [N-1:0] prs, iss;
    logic nd;
    int win;
    prs = '0; iss = '0; win = -1;
    if (m_cnt == TD - 1) begin
      for (int i = 0; i < N; i++) begin
        if (m_s2[i]) begin m_ones[i]++;  m_zeros[i] = 0; end
        else         begin m_zeros[i]++; m_ones[i]  = 0; end
        nd = (m_ones[i] >= SN) ? 1'b1 : (m_zeros[i] >= SN) ? 1'b0 : m_deb[i];
        prs[i]   = nd && !m_deb[i];
        m_deb[i] = nd;
      end
    end
    if (!m_valid || rdy) begin
      for (int k = 1; k <= N; k++)
        if (win < 0 && m_pend[(m_last + k) % N]) win = (m_last + k) % N;
      if (win >= 0) begin
        m_valid = 1'b1; m_id = win; m_last = win; iss[win] = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_ovr  = m_ovr | (prs & m_pend & ~iss);
    m_pend = (m_pend & ~iss) | prs;
    m_s2   = m_s1;
    m_s1   = raw;
    m_cnt  = (m_cnt + 1) % TD;
  endtask

  // Called at a falling edge: drive, clock, advance the model, compare at the next falling edge.
  task automatic step(input logic [N-1:0] raw, input logic rdy);
    btn_raw   = raw;
    cmd_ready = rdy;
    if (cmd_valid === 1'b1 && rdy) begin
      acc_id.push_back(int'(cmd_id));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge(raw, rdy);
    @(negedge clk);
    cyc++;
    check("cmd_valid", cmd_valid, m_valid);
    check("pending", pending, m_pend);
    check("overrun", overrun, m_ovr);
    check("tick", dut.tick, m_cnt == TD - 1);
    if (m_valid) check("cmd_id", cmd_id, m_id);
  endtask

  task automatic hold(input logic [N-1:0] raw, input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(raw, rdy);
  endtask

  task automatic hold_stalled(input logic [N-1:0] raw, input int n);
    for (int i = 0; i < n; i++) begin
      step(raw, 1'b0);
      check("stall_valid", cmd_valid, 1);
      check("stall_id", cmd_id, 1);
    end
  endtask

  typedef struct {
    logic [N-1:0] raw;
    int           n;
    int           id[N];
  } vec_t;

  vec_t tbl[5];

  initial begin
    int start, tpos[$];
    logic [N-1:0] rraw;
    int hold_left[N];

    tbl[0] = '{raw: 4'b1011, n: 3, id: '{0, 1, 3, 0}};
    tbl[1] = '{raw: 4'b1001, n: 2, id: '{0, 3, 0, 0}};
    tbl[2] = '{raw: 4'b0100, n: 1, id: '{2, 0, 0, 0}};
    tbl[3] = '{raw: 4'b1111, n: 4, id: '{3, 0, 1, 2}};
    tbl[4] = '{raw: 4'b0110, n: 2, id: '{1, 2, 0, 0}};

    rst_n = 1'b0; btn_raw = '0; cmd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_id", cmd_id, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Directed press table with cmd_ready held high; commands must be back-to-back.
    for (int v = 0; v < 5; v++) begin
      acc_id.delete(); acc_cyc.delete();
      start = cyc;
      hold(tbl[v].raw, 1'b1, 24);
      hold('0, 1'b1, 24);
      check("tbl_count", acc_id.size(), tbl[v].n);
      if (acc_id.size() == tbl[v].n) begin
        check("tbl_latency_ok", (acc_cyc[0] - start) <= 16, 1);
        for (int k = 0; k < tbl[v].n; k++) begin
          check("tbl_id", acc_id[k], tbl[v].id[k]);
          if (k > 0) check("tbl_b2b", acc_cyc[k] - acc_cyc[k-1], 1);
        end
      end
    end

    // Bounce: toggling every 3 cycles never yields 3 equal tick samples.
    acc_id.delete(); acc_cyc.delete();
    for (int c = 0; c < 30; c++) step({3'b000, ((c / 3) % 2) == 0}, 1'b1);
    check("bounce_quiet", acc_id.size(), 0);
    hold(4'b0001, 1'b1, 24);
    hold('0, 1'b1, 24);
    check("bounce_count", acc_id.size(), 1);
    if (acc_id.size() == 1) check("bounce_id", acc_id[0], 0);
    check("bounce_overrun", overrun, 0);

    // Backpressure on button 1.
    acc_id.delete(); acc_cyc.delete();
    hold(4'b0010, 1'b0, 24);
    check("bp_valid", cmd_valid, 1);
    check("bp_id", cmd_id, 1);
    hold_stalled('0, 24);
    hold_stalled(4'b0010, 24);
    check("bp_pend1", pending[1], 1);
    check("bp_ovr1_clear", overrun[1], 0);
    hold_stalled('0, 24);
    hold_stalled(4'b0010, 24);
    check("bp_ovr1_set", overrun[1], 1);
    hold_stalled('0, 24);
    hold('0, 1'b1, 10);
    check("bp_count", acc_id.size(), 2);
    for (int k = 0; k < acc_id.size(); k++) check("bp_cmd_id", acc_id[k], 1);

    // Reset while a command is offered and two requests wait.
    hold(4'b0001, 1'b0, 24);
    hold('0, 1'b0, 24);
    hold(4'b1010, 1'b0, 24);
    hold('0, 1'b0, 24);
    check("pre_rst_valid", cmd_valid, 1);
    check("pre_rst_pending", pending, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_id", cmd_id, 0);
    check("arst_pending", pending, 0);
    check("arst_overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Tick wrap straight after reset release, then confirm nothing is issued.
    acc_id.delete(); acc_cyc.delete();
    tpos.delete();
    for (int c = 0; c < 3 * TD; c++) begin
      step('0, 1'b1);
      if (dut.tick === 1'b1) tpos.push_back(c);
    end
    check("tick_count", tpos.size(), 3);
    for (int k = 1; k < tpos.size(); k++) check("tick_period", tpos[k] - tpos[k-1], TD);
    hold('0, 1'b1, 40);
    check("post_rst_cmds", acc_id.size(), 0);

    // Randomized buttons and backpressure against the model.
    rraw = '0;
    for (int i = 0; i < N; i++) hold_left[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        hold_left[i]--;
        if (hold_left[i] == 0) begin
          rraw[i]      = ~rraw[i];
          hold_left[i] = (c % 500 < 100) ? $urandom_range(1, 6) : $urandom_range(1, 40);
        end
      end
      step(rraw, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
